// File: rtl/stream_arb_pkg.sv
// Shared types and parameter limits for the packet-level round-robin stream arbiter.
package stream_arb_pkg;

    // Arbitration FSM: IDLE picks the next requester, LOCK streams one whole packet from it.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam int MIN_IN = 2;
    localparam int MAX_IN = 16;
    localparam int MIN_DATA_W = 1;

    // True when the requester count is inside the supported range.
    function automatic bit numInOk(input int n);
        return (n >= MIN_IN) && (n <= MAX_IN);
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the NUM_IN input streams and the single merged output stream.
// slave is the arbiter's view; master is the view of the producers and consumer around it.
interface stream_rr_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]        inValid;
    logic [NUM_IN-1:0]        inLast;
    logic [NUM_IN*DATA_W-1:0] inData;
    logic [NUM_IN-1:0]        inReady;
    logic                     outValid;
    logic                     outReady;
    logic [DATA_W-1:0]        outData;
    logic                     outLast;
    logic [ID_W-1:0]          outId;

    modport slave (
        input  inValid, inLast, inData, outReady,
        output inReady, outValid, outData, outLast, outId
    );

    modport master (
        output inValid, inLast, inData, outReady,
        input  inReady, outValid, outData, outLast, outId
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching ptr+1, ptr+2, ... mod N.
// Rotates the request vector so ptr+1 lands at bit 0, priority-encodes, then un-rotates the index.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0] rot;
    int           off;

    // Rotate, lowest-set-bit encode, un-rotate back to a requester index.
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rot = '0;
        off = 0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[(int'(ptr) + 1 + k) % N];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
            end
        end
        found = |rot;
        idx   = ID_W'((int'(ptr) + 1 + off) % N);
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_IN valid/ready streams into one registered
// output stream. A grant is held for a whole packet; outId tags the source of every beat.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    stream_rr_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_IN);

    if (!numInOk(NUM_IN) || (DATA_W < MIN_DATA_W)) begin : gBadParam
        $error("stream_rr_arbiter: NUM_IN must be 2..16 and DATA_W >= 1");
    end

    arb_state_t        state, stateNext;
    logic [ID_W-1:0]   grant, grantNext;
    logic [ID_W-1:0]   ptr, ptrNext;
    logic              pickFound;
    logic [ID_W-1:0]   pickIdx;
    logic              ld;
    logic              accept;
    logic              selValid;
    logic              selLast;
    logic [DATA_W-1:0] selData;

    rr_pick #(.N(NUM_IN)) uPick (
        .req   (bus.inValid),
        .ptr   (ptr),
        .found (pickFound),
        .idx   (pickIdx)
    );

    // The output register can take a new beat when empty or being drained this cycle.
    assign ld = !bus.outValid || bus.outReady;

    // Select the granted requester's beat.
    always_comb begin
        selValid = bus.inValid[grant];
        selLast  = bus.inLast[grant];
        selData  = bus.inData[int'(grant)*DATA_W +: DATA_W];
    end

    // Only the granted requester sees ready, and only while the output can load.
    always_comb begin
        bus.inReady = '0;
        if (state == ST_LOCK && ld) begin
            bus.inReady[grant] = 1'b1;
        end
    end

    assign accept = (state == ST_LOCK) && ld && selValid;

    // Next-state logic: arbitrate in IDLE, release the lock after the accepted last beat.
    always_comb begin
        stateNext = state;
        grantNext = grant;
        ptrNext   = ptr;
        case (state)
            ST_IDLE: begin
                if (pickFound) begin
                    stateNext = ST_LOCK;
                    grantNext = pickIdx;
                end
            end
            ST_LOCK: begin
                if (accept && selLast) begin
                    stateNext = ST_IDLE;
                    ptrNext   = grant;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers; ptr starts at NUM_IN-1 so input 0 goes first.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= ID_W'(NUM_IN - 1);
        end else begin
            state <= stateNext;
            grant <= grantNext;
            ptr   <= ptrNext;
        end
    end

    // Output control: load on an accepted beat, otherwise drain when downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.outValid <= 1'b0;
            bus.outLast  <= 1'b0;
            bus.outId    <= '0;
        end else if (accept) begin
            bus.outValid <= 1'b1;
            bus.outLast  <= selLast;
            bus.outId    <= grant;
        end else if (bus.outReady) begin
            bus.outValid <= 1'b0;
        end
    end

    // Output payload register.
    // NOTE: payload is left unreset; it is only meaningful while outValid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            bus.outData <= selData;
        end
    end

    aReadyOneHot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.inReady));

    aOutHold: assert property (@(posedge clk) disable iff (rst)
        bus.outValid && !bus.outReady |=>
            $stable({bus.outValid, bus.outData, bus.outLast, bus.outId}));

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (NUM_IN=4 and NUM_IN=3 instances).
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NUM_IN(4), .DATA_W(8)) bus4 ();
    stream_rr_arbiter_if #(.NUM_IN(3), .DATA_W(8)) bus3 ();

    stream_rr_arbiter #(.NUM_IN(4), .DATA_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    stream_rr_arbiter #(.NUM_IN(3), .DATA_W(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    int checks = 0;
    int failures = 0;

    int         cnt [4];
    int         pktLen = 1;
    logic [3:0] vmask = '0;
    int         logId [$];
    int         logData [$];
    int         logLast [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive each 4-input requester from its beat counter: data = count, last every pktLen beats.
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus4.inData[i*8 +: 8] = 8'(cnt[i]);
            bus4.inLast[i]        = ((cnt[i] % pktLen) == pktLen - 1);
        end
        bus4.inValid = vmask;
    endtask

    // One clock: sample handshakes before the edge, log output beats, check hold, advance sources.
    task automatic step();
        logic [3:0] fire;
        logic       oFire;
        logic       hold;
        logic [7:0] sData;
        logic [1:0] sId;
        logic       sLast;
        #3;
        fire  = bus4.inValid & bus4.inReady;
        oFire = bus4.outValid && bus4.outReady;
        hold  = bus4.outValid && !bus4.outReady;
        sData = bus4.outData;
        sId   = bus4.outId;
        sLast = bus4.outLast;
        check("onehot_inReady", 32'($onehot0(bus4.inReady)), 1);
        if (oFire) begin
            logId.push_back(int'(sId));
            logData.push_back(int'(sData));
            logLast.push_back(int'(sLast));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) cnt[i]++;
        end
        if (hold) begin
            check("hold_valid", bus4.outValid, 1);
            check("hold_data", bus4.outData, sData);
            check("hold_id", bus4.outId, sId);
            check("hold_last", bus4.outLast, sLast);
        end
        drive();
    endtask

    task automatic clearLog();
        logId.delete();
        logData.delete();
        logLast.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        vmask = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bus4.outReady = 1'b1;
        drive();
        bus3.inValid  = '0;
        bus3.inLast   = '0;
        bus3.inData   = '0;
        bus3.outReady = 1'b1;
        clearLog();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int expNext [4];
        int n;

        // Reset state.
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bus4.outReady = 1'b1;
        drive();
        bus3.inValid = '0; bus3.inLast = '0; bus3.inData = '0; bus3.outReady = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outValid", bus4.outValid, 0);
        check("rst_outLast", bus4.outLast, 0);
        check("rst_outId", bus4.outId, 0);
        check("rst_inReady", bus4.inReady, 0);
        check("rst3_outValid", bus3.outValid, 0);
        rst = 1'b0;

        // Inputs 0 and 2, single-beat packets: ids alternate 0,2,0,2...
        vmask = 4'b0101; pktLen = 1; drive();
        for (int k = 0; k < 40 && logId.size() < 6; k++) step();
        check("t2_beats", logId.size(), 6);
        for (int b = 0; b < logId.size(); b++) begin
            check("t2_id", logId[b], (b % 2 == 0) ? 0 : 2);
            check("t2_data", logData[b], b / 2);
            check("t2_last", logLast[b], 1);
        end

        // All inputs valid, 3-beat packets: contiguous packets in id order 0,1,2,3,0.
        doReset();
        vmask = 4'b1111; pktLen = 3; drive();
        for (int k = 0; k < 100 && logId.size() < 15; k++) step();
        check("t3_beats", logId.size(), 15);
        for (int b = 0; b < logId.size(); b++) begin
            check("t3_id", logId[b], (b / 3) % 4);
            check("t3_last", logLast[b], (b % 3 == 2) ? 1 : 0);
            check("t3_data", logData[b], ((b / 3) / 4) * 3 + (b % 3));
        end

        // Input 1 stalls mid-packet while input 3 waits: grant stays on 1 until its last beat.
        doReset();
        vmask = 4'b0010; pktLen = 3; drive();
        for (int k = 0; k < 20 && logId.size() < 1; k++) step();
        check("t4_first_beat", logId.size(), 1);
        vmask = 4'b1000; drive();
        repeat (5) begin
            step();
            check("t4_hold_grant", bus4.inReady, 4'b0010);
        end
        vmask = 4'b1010; drive();
        for (int k = 0; k < 30 && logId.size() < 4; k++) step();
        check("t4_beats", logId.size(), 4);
        if (logId.size() >= 4) begin
            check("t4_id0", logId[0], 1);
            check("t4_id1", logId[1], 1);
            check("t4_id2", logId[2], 1);
            check("t4_last2", logLast[2], 1);
            check("t4_data2", logData[2], 2);
            check("t4_id3", logId[3], 3);
            check("t4_data3", logData[3], 0);
        end

        // Random back-pressure over 200 beats: per-id data gapless and in order.
        doReset();
        vmask = 4'b1111; pktLen = 2; drive();
        for (int i = 0; i < 4; i++) expNext[i] = 0;
        for (int k = 0; k < 2000 && logId.size() < 200; k++) begin
            bus4.outReady = 1'($urandom_range(0, 1));
            step();
        end
        check("t5_beats", logId.size(), 200);
        for (int b = 0; b < logId.size(); b++) begin
            check("t5_id_range", 32'(logId[b] < 4), 1);
            if (logId[b] < 4) begin
                check("t5_seq", logData[b], expNext[logId[b]] & 8'hFF);
                check("t5_last", logLast[b], (expNext[logId[b]] % 2 == 1) ? 1 : 0);
                expNext[logId[b]]++;
            end
        end

        // Reset mid-packet with a held output beat: async clear, then restart at lowest valid id.
        doReset();
        vmask = 4'b0100; pktLen = 4; bus4.outReady = 1'b0; drive();
        for (int k = 0; k < 10 && !bus4.outValid; k++) step();
        check("t6_pre_outValid", bus4.outValid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_outValid", bus4.outValid, 0);
        check("t6_rst_inReady", bus4.inReady, 0);
        check("t6_rst_outLast", bus4.outLast, 0);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        vmask = 4'b1010; bus4.outReady = 1'b1; drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("t6_first_grant", bus4.inReady, 4'b0010);

        // NUM_IN=3, inputs 0 and 2: grant wraps 2 -> 0, id 3 never appears.
        doReset();
        bus3.inData  = {8'h22, 8'h11, 8'h00};
        bus3.inLast  = 3'b111;
        bus3.inValid = 3'b101;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus3.outValid) begin
                check("t7_id_not3", 32'(bus3.outId != 2'd3), 1);
                check("t7_id", bus3.outId, (n % 2 == 0) ? 0 : 2);
                check("t7_data", bus3.outData, (n % 2 == 0) ? 8'h00 : 8'h22);
                n++;
            end
        end
        check("t7_beats", n, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
